// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU / mult-div sources and the register file write port.
// The source side (master) offers results; the arbiter (slave) drives the regfile strobe.
interface regfile_write_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        alu_stall;
  logic [31:0] pending_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport master (
    output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
    input  md_ready, alu_stall, pending_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
    output md_ready, alu_stall, pending_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: merges the never-waiting ALU path with a FIFO of
// long-latency mult/div results, killing stale queued writes and bounding FIFO starvation.
module regfile_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input logic                    clock,
  input logic                    ctrl_reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

  logic [4:0]       rd_mem_r   [DEPTH];
  logic [31:0]      data_mem_r [DEPTH];
  logic [DEPTH-1:0] live_r;
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [WW-1:0]    wait_r;
  logic             we_r;
  logic [4:0]       wreg_r;
  logic [31:0]      wdata_r;

  logic             head_valid_s;
  logic             md_ready_s;
  logic             push_s;
  logic             alu_req_s;
  logic             force_s;
  logic             pop_s;
  logic             alu_win_s;
  logic             wr_en_s;
  logic [4:0]       wr_reg_s;
  logic [31:0]      wr_data_s;
  logic [DEPTH-1:0] live_kill_s;
  logic [DEPTH-1:0] live_next_s;
  logic [31:0]      mask_s;

  assign head_valid_s = (count_r != {CW{1'b0}});
  assign md_ready_s   = (count_r < DEPTH_C);
  assign push_s       = bus.md_valid && md_ready_s && (bus.md_rd != 5'd0);
  assign alu_req_s    = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign force_s      = head_valid_s && (wait_r == MAX_WAIT_C);

  // Port arbitration: a starved head beats the ALU, otherwise the ALU beats the FIFO.
  always_comb begin
    pop_s     = 1'b0;
    alu_win_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_reg_s  = rd_mem_r[head_r];
    wr_data_s = data_mem_r[head_r];
    if (force_s) begin
      pop_s   = 1'b1;
      wr_en_s = live_r[head_r];
    end else if (alu_req_s) begin
      alu_win_s = 1'b1;
      wr_en_s   = 1'b1;
      wr_reg_s  = bus.alu_rd;
      wr_data_s = bus.alu_data;
    end else if (head_valid_s) begin
      pop_s   = 1'b1;
      wr_en_s = live_r[head_r];
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Kill older queued writes to the ALU's register, then derive the pending mask and next live bits.
  always_comb begin
    live_kill_s = live_r;
    mask_s      = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_win_s && (rd_mem_r[i] == bus.alu_rd)) begin
        live_kill_s[i] = 1'b0;
      end else begin
        live_kill_s[i] = live_r[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (live_kill_s[i] && !(pop_s && (head_r == AW'(i)))) begin
        mask_s[rd_mem_r[i]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0]   = 1'b0;
    live_next_s = live_kill_s;
    if (pop_s) begin
      live_next_s[head_r] = 1'b0;
    end else begin
      live_next_s = live_next_s;
    end
    // A same-cycle push is younger than the ALU write, so it is set after the kill.
    if (push_s) begin
      live_next_s[tail_r] = 1'b1;
    end else begin
      live_next_s = live_next_s;
    end
  end

  // FIFO storage, pointers, occupancy and head starvation counter.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= 32'd0;
      end
      live_r  <= {DEPTH{1'b0}};
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      wait_r  <= {WW{1'b0}};
    end else begin
      live_r <= live_next_s;
      if (push_s) begin
        rd_mem_r[tail_r]   <= bus.md_rd;
        data_mem_r[tail_r] <= bus.md_data;
        tail_r             <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s || !head_valid_s) begin
        wait_r <= {WW{1'b0}};
      end else if (alu_win_s) begin
        wait_r <= wait_r + WW'(1);
      end
    end
  end

  // Registered write port; index and data hold while no write is issued.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_r    <= 1'b0;
      wreg_r  <= 5'd0;
      wdata_r <= 32'd0;
    end else if (wr_en_s) begin
      we_r    <= 1'b1;
      wreg_r  <= wr_reg_s;
      wdata_r <= wr_data_s;
    end else begin
      we_r <= 1'b0;
    end
  end

  assign bus.md_ready         = md_ready_s;
  assign bus.alu_stall        = force_s;
  assign bus.pending_mask     = mask_s;
  assign bus.ctrl_writeEnable = we_r;
  assign bus.ctrl_writeReg    = wreg_r;
  assign bus.data_writeReg    = wdata_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset corner case, then random
// traffic checked against a queue-based model of the writeback rules.
module tb_regfile_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  logic clock = 1'b0;
  logic ctrl_reset_n;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus.slave)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_ready;
    logic        e_stall;
    logic [31:0] e_mask;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  int   wait_m;
  logic m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit   prev_force;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic er, input logic es, input logic [31:0] em,
                     input logic ew, input logic [4:0] eg, input logic [31:0] ed);
    vec_t v;
    v = '{av, ard, ad, mv, mrd, md, er, es, em, ew, eg, ed};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clock);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.md_valid  = mv;
    bus.md_rd     = mrd;
    bus.md_data   = md;
  endtask

  // One cycle of the reference rules: checks combinational outputs, then advances the model.
  task automatic model_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                             input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit full, frc, pop, wr;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] mask;
    ent_t e;
    full = (q.size() >= DEPTH);
    frc  = (q.size() > 0) && (wait_m == MAX_WAIT);
    pop  = 1'b0;
    wr   = 1'b0;
    wrd  = 5'd0;
    wd   = 32'd0;
    if (frc) begin
      pop = 1'b1; wr = q[0].live; wrd = q[0].rd; wd = q[0].data;
    end else if (av && ard != 5'd0) begin
      wr = 1'b1; wrd = ard; wd = ad;
      foreach (q[k]) if (q[k].rd == ard) q[k].live = 1'b0;
      if (q.size() > 0) wait_m++;
    end else if (q.size() > 0) begin
      pop = 1'b1; wr = q[0].live; wrd = q[0].rd; wd = q[0].data;
    end
    mask = 32'd0;
    for (int k = (pop ? 1 : 0); k < q.size(); k++) if (q[k].live) mask[q[k].rd] = 1'b1;
    mask[0] = 1'b0;
    chk("rnd_md_ready", {31'd0, bus.md_ready}, {31'd0, !full});
    chk("rnd_alu_stall", {31'd0, bus.alu_stall}, {31'd0, frc});
    chk("rnd_pending_mask", bus.pending_mask, mask);
    if (pop) begin
      void'(q.pop_front());
      wait_m = 0;
    end
    if (mv && !full && mrd != 5'd0) begin
      e = '{mrd, md, 1'b1};
      q.push_back(e);
    end
    if (q.size() == 0) wait_m = 0;
    m_we = wr;
    if (wr) begin
      m_reg  = wrd;
      m_data = wd;
    end
    prev_force = frc;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.md_valid  = 1'b0; bus.md_rd  = 5'd0; bus.md_data  = 32'd0;

    for (int i = 0; i < 5; i++)
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    add(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF);
    add(1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 32'h0,  1'b1, 5'd20, 32'hA0);
    add(1'b1, 5'd20, 32'hA1, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 32'h2,  1'b1, 5'd20, 32'hA1);
    add(1'b1, 5'd20, 32'hA2, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 32'h6,  1'b1, 5'd20, 32'hA2);
    add(1'b1, 5'd20, 32'hA3, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 32'hE,  1'b1, 5'd20, 32'hA3);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'h1C, 1'b1, 5'd1,  32'h11);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h18, 1'b1, 5'd2,  32'h22);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h10, 1'b1, 5'd3,  32'h33);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 5'd4,  32'h44);
    add(1'b0, 5'd0,  32'h0,  1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 32'h0,  1'b0, 5'd4,  32'h44);
    add(1'b1, 5'd9,  32'h90, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h80, 1'b1, 5'd9,  32'h90);
    add(1'b1, 5'd9,  32'h91, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h80, 1'b1, 5'd9,  32'h91);
    add(1'b1, 5'd9,  32'h92, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h80, 1'b1, 5'd9,  32'h92);
    add(1'b1, 5'd9,  32'h93, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 5'd7,  32'h77);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 5'd7,  32'h77);
    add(1'b0, 5'd0,  32'h0,  1'b1, 5'd6, 32'hAA, 1'b1, 1'b0, 32'h0,  1'b0, 5'd7,  32'h77);
    add(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h40, 1'b1, 5'd12, 32'hC0);
    add(1'b1, 5'd6,  32'hBB, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 5'd6,  32'hBB);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 5'd6,  32'hBB);
    add(1'b1, 5'd0,  32'h66, 1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 32'h0,  1'b0, 5'd6,  32'hBB);
    add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 5'd6,  32'hBB);
    add(1'b1, 5'd10, 32'hD0, 1'b1, 5'd2, 32'hE2, 1'b1, 1'b0, 32'h0,  1'b1, 5'd10, 32'hD0);
    add(1'b1, 5'd10, 32'hD1, 1'b1, 5'd3, 32'hE3, 1'b1, 1'b0, 32'h4,  1'b1, 5'd10, 32'hD1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      #1;
      chk("tbl_md_ready", {31'd0, bus.md_ready}, {31'd0, tbl[i].e_ready});
      chk("tbl_alu_stall", {31'd0, bus.alu_stall}, {31'd0, tbl[i].e_stall});
      chk("tbl_pending_mask", bus.pending_mask, tbl[i].e_mask);
      @(posedge clock);
      #1;
      chk("tbl_write_enable", {31'd0, bus.ctrl_writeEnable}, {31'd0, tbl[i].e_we});
      chk("tbl_write_reg", {27'd0, bus.ctrl_writeReg}, {27'd0, tbl[i].e_reg});
      chk("tbl_write_data", bus.data_writeReg, tbl[i].e_data);
    end

    // Two entries are queued here; an async reset must drop them.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 ctrl_reset_n = 1'b0;
    #1;
    chk("rst_write_enable", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    chk("rst_write_reg", {27'd0, bus.ctrl_writeReg}, 32'd0);
    chk("rst_write_data", bus.data_writeReg, 32'd0);
    chk("rst_pending_mask", bus.pending_mask, 32'd0);
    chk("rst_md_ready", {31'd0, bus.md_ready}, 32'd1);
    chk("rst_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      chk("post_rst_no_write", {31'd0, bus.ctrl_writeEnable}, 32'd0);
      chk("post_rst_mask", bus.pending_mask, 32'd0);
    end

    q.delete();
    wait_m = 0; m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0; prev_force = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic av, mv;
      logic [4:0] ard, mrd;
      logic [31:0] ad, md;
      av  = prev_force ? 1'b0 : 1'($urandom_range(0, 1));
      ard = 5'($urandom_range(0, 7));
      ad  = 32'($urandom());
      mv  = 1'($urandom_range(0, 1));
      mrd = 5'($urandom_range(0, 7));
      md  = 32'($urandom());
      drive(av, ard, ad, mv, mrd, md);
      #1;
      model_cycle(av, ard, ad, mv, mrd, md);
      @(posedge clock);
      #1;
      chk("rnd_write_enable", {31'd0, bus.ctrl_writeEnable}, {31'd0, m_we});
      chk("rnd_write_reg", {27'd0, bus.ctrl_writeReg}, {27'd0, m_reg});
      chk("rnd_write_data", bus.data_writeReg, m_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
